// File: rtl/axi_sched_pkg.sv
// axi_sched_pkg
//   Shared types and helpers for the AXI burst scheduler.
//   - sched_state_t : scheduler FSM state encoding
//   - RESP_OKAY     : AXI BRESP value for a clean write
//   - burst_bytes() : bytes moved by one burst (beats * beat width / 8)
package axi_sched_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StArb,
        StIssueRd,
        StIssueWr,
        StDrain,
        StDone
    } sched_state_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    function automatic int unsigned burst_bytes(input int unsigned burst_len,
                                                input int unsigned axi_width);
        return (burst_len * axi_width) / 8;
    endfunction

endpackage

// File: rtl/axi_sched_rr_arb.sv
// axi_sched_rr_arb
//   Two-way arbiter between the read and write requesters of the burst scheduler.
//   Default build: round-robin, the side not granted last wins a contested grant.
//   With AXI_SCHED_RD_PRIORITY_EN defined: fixed priority, reads always win.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   clr             return the round-robin pointer to its reset value (layer start)
//   take            a grant raised this cycle is being consumed
//   req_rd, req_wr  requests (eligibility) from each side
//   gnt_rd, gnt_wr  one-hot (or zero) grant, combinational from the requests
module axi_sched_rr_arb (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic take,
    input  logic req_rd,
    input  logic req_wr,
    output logic gnt_rd,
    output logic gnt_wr
);

`ifdef AXI_SCHED_RD_PRIORITY_EN

    always_comb begin
        gnt_rd = req_rd;
        gnt_wr = req_wr & ~req_rd;
    end

`else

    // 1: write was granted last, so read wins the next contest.
    logic last_wr_q;

    always_comb begin
        gnt_rd = req_rd & (~req_wr | last_wr_q);
        gnt_wr = req_wr & (~req_rd | ~last_wr_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            last_wr_q <= 1'b1;
        end else if (take && (gnt_rd || gnt_wr)) begin
            last_wr_q <= gnt_wr;
        end
    end

`endif

endmodule

// File: rtl/axi_burst_scheduler.sv
// axi_burst_scheduler
//   Sequences one convolution layer's AXI traffic: IFM read bursts into the input FIFO,
//   OFM write bursts out of the output FIFO, sharing one command path via a 2-way arbiter.
//   Also generates the CNN start pulse and the layer-done pulse. All outputs are registered.
//   Optional macro: AXI_SCHED_RD_PRIORITY_EN (reads win contested grants instead of RR).
// Ports:
//   ACLK, ARESETN                       clock, synchronous active-low reset
//   cfg_start, cfg_*_base, cfg_*_bursts layer configuration, sampled on cfg_start in idle
//   ifm_level, ofm_level                FIFO occupancies in beats
//   rd_cmd_*, wr_cmd_*                  command valid/ready handshake with address and length
//   rd_done, wr_done, wr_resp           burst completion pulses (BRESP qualified by wr_done)
//   busy, start_cnn, layer_done         layer status and one-cycle pulses
//   resp_err                            sticky flag for any non-OKAY write response
module axi_burst_scheduler #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned AXI_WIDTH  = 256,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned BURST_LEN  = 256,
    parameter int unsigned FIFO_DEPTH = 1536,
    parameter int unsigned LVL_WIDTH  = 11,
    parameter int unsigned NB_WIDTH   = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  cfg_start,
    input  logic [ADDR_WIDTH-1:0] cfg_ifm_base,
    input  logic [ADDR_WIDTH-1:0] cfg_ofm_base,
    input  logic [NB_WIDTH-1:0]   cfg_ifm_bursts,
    input  logic [NB_WIDTH-1:0]   cfg_ofm_bursts,
    input  logic [LVL_WIDTH-1:0]  ifm_level,
    input  logic [LVL_WIDTH-1:0]  ofm_level,
    output logic                  rd_cmd_valid,
    input  logic                  rd_cmd_ready,
    output logic [ADDR_WIDTH-1:0] rd_cmd_addr,
    output logic [LEN_WIDTH-1:0]  rd_cmd_len,
    input  logic                  rd_done,
    output logic                  wr_cmd_valid,
    input  logic                  wr_cmd_ready,
    output logic [ADDR_WIDTH-1:0] wr_cmd_addr,
    output logic [LEN_WIDTH-1:0]  wr_cmd_len,
    input  logic                  wr_done,
    input  logic [1:0]            wr_resp,
    output logic                  busy,
    output logic                  start_cnn,
    output logic                  layer_done,
    output logic                  resp_err
);

    import axi_sched_pkg::*;

    localparam int unsigned         BurstBytes = burst_bytes(BURST_LEN, AXI_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] AddrStep = ADDR_WIDTH'(BurstBytes);
    localparam logic [LVL_WIDTH-1:0]  RdLvlMax = LVL_WIDTH'(FIFO_DEPTH - BURST_LEN);
    localparam logic [LVL_WIDTH-1:0]  WrLvlMin = LVL_WIDTH'(BURST_LEN);
    localparam logic [LEN_WIDTH-1:0]  CmdLen   = LEN_WIDTH'(BURST_LEN - 1);
    localparam logic [NB_WIDTH-1:0]   NbOne    = NB_WIDTH'(1);
    localparam logic [NB_WIDTH-1:0]   NbTwo    = NB_WIDTH'(2);

    sched_state_t state_q, state_d;

    logic [NB_WIDTH-1:0]   ifm_bursts_q, ofm_bursts_q;
    logic [NB_WIDTH-1:0]   rd_issued_q, rd_compl_q, wr_issued_q, wr_compl_q;
    logic [NB_WIDTH-1:0]   rd_compl_d, cnn_target;
    logic [LVL_WIDTH-1:0]  ifm_level_q, ofm_level_q;
    // The address registers double as the running burst pointers.
    logic [ADDR_WIDTH-1:0] rd_addr_q, wr_addr_q;
    logic                  rd_valid_q, wr_valid_q, busy_q, start_cnn_q, layer_done_q;
    logic                  rd_valid_d, wr_valid_d, busy_d, layer_done_d;
    logic                  resp_err_q, cnn_started_q;

    logic layer_start, rd_hs, wr_hs, rd_compl_inc, wr_compl_inc;
    logic rd_elig, wr_elig, gnt_rd, gnt_wr, all_issued, all_compl, start_fire;

    assign layer_start = (state_q == StIdle) && cfg_start;
    assign rd_hs       = (state_q == StIssueRd) && rd_cmd_ready;
    assign wr_hs       = (state_q == StIssueWr) && wr_cmd_ready;

    // A done counts only against a burst that is outstanding or being issued right now.
    assign rd_compl_inc = rd_done && ((rd_issued_q != rd_compl_q) || rd_hs);
    assign wr_compl_inc = wr_done && ((wr_issued_q != wr_compl_q) || wr_hs);

    assign rd_elig = (rd_issued_q < ifm_bursts_q) && (rd_issued_q == rd_compl_q) &&
                     (ifm_level_q <= RdLvlMax);
    assign wr_elig = (wr_issued_q < ofm_bursts_q) && (wr_issued_q == wr_compl_q) &&
                     (ofm_level_q >= WrLvlMin);

    assign all_issued = (rd_issued_q == ifm_bursts_q) && (wr_issued_q == ofm_bursts_q);
    assign all_compl  = (rd_compl_q == ifm_bursts_q) && (wr_compl_q == ofm_bursts_q);

    axi_sched_rr_arb u_arb (
        .clk    (ACLK),
        .rst_n  (ARESETN),
        .clr    (layer_start),
        .take   (state_q == StArb),
        .req_rd (rd_elig),
        .req_wr (wr_elig),
        .gnt_rd (gnt_rd),
        .gnt_wr (gnt_wr)
    );

    // State register
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (cfg_start) state_d = StArb;
            StArb: begin
                if (gnt_rd) begin
                    state_d = StIssueRd;
                end else if (gnt_wr) begin
                    state_d = StIssueWr;
                end else if (all_issued) begin
                    state_d = StDrain;
                end
            end
            StIssueRd: if (rd_cmd_ready) state_d = StArb;
            StIssueWr: if (wr_cmd_ready) state_d = StArb;
            StDrain:   if (all_compl) state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        rd_valid_d   = (state_d == StIssueRd);
        wr_valid_d   = (state_d == StIssueWr);
        busy_d       = (state_d != StIdle);
        layer_done_d = (state_d == StDone);
        rd_compl_d   = rd_compl_q + (rd_compl_inc ? NbOne : '0);
        cnn_target   = (ifm_bursts_q >= NbTwo) ? NbTwo : ifm_bursts_q;
        start_fire   = (state_q != StIdle) && !cnn_started_q && (ifm_bursts_q != '0) &&
                       (rd_compl_d == cnn_target);
    end

    // Datapath and output registers
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            ifm_bursts_q  <= '0;
            ofm_bursts_q  <= '0;
            rd_issued_q   <= '0;
            rd_compl_q    <= '0;
            wr_issued_q   <= '0;
            wr_compl_q    <= '0;
            ifm_level_q   <= '0;
            ofm_level_q   <= '0;
            rd_addr_q     <= '0;
            wr_addr_q     <= '0;
            rd_valid_q    <= 1'b0;
            wr_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            start_cnn_q   <= 1'b0;
            layer_done_q  <= 1'b0;
            resp_err_q    <= 1'b0;
            cnn_started_q <= 1'b0;
        end else begin
            ifm_level_q  <= ifm_level;
            ofm_level_q  <= ofm_level;
            rd_valid_q   <= rd_valid_d;
            wr_valid_q   <= wr_valid_d;
            busy_q       <= busy_d;
            layer_done_q <= layer_done_d;
            start_cnn_q  <= start_fire;
            if (layer_start) begin
                ifm_bursts_q  <= cfg_ifm_bursts;
                ofm_bursts_q  <= cfg_ofm_bursts;
                rd_issued_q   <= '0;
                rd_compl_q    <= '0;
                wr_issued_q   <= '0;
                wr_compl_q    <= '0;
                rd_addr_q     <= cfg_ifm_base;
                wr_addr_q     <= cfg_ofm_base;
                resp_err_q    <= 1'b0;
                cnn_started_q <= 1'b0;
            end else begin
                if (rd_hs) begin
                    rd_issued_q <= rd_issued_q + NbOne;
                    rd_addr_q   <= rd_addr_q + AddrStep;
                end
                if (wr_hs) begin
                    wr_issued_q <= wr_issued_q + NbOne;
                    wr_addr_q   <= wr_addr_q + AddrStep;
                end
                rd_compl_q <= rd_compl_d;
                if (wr_compl_inc) begin
                    wr_compl_q <= wr_compl_q + NbOne;
                    if (wr_resp != RESP_OKAY) resp_err_q <= 1'b1;
                end
                if (start_fire) cnn_started_q <= 1'b1;
            end
        end
    end

    assign rd_cmd_valid = rd_valid_q;
    assign wr_cmd_valid = wr_valid_q;
    assign rd_cmd_addr  = rd_addr_q;
    assign wr_cmd_addr  = wr_addr_q;
    assign rd_cmd_len   = CmdLen;
    assign wr_cmd_len   = CmdLen;
    assign busy         = busy_q;
    assign start_cnn    = start_cnn_q;
    assign layer_done   = layer_done_q;
    assign resp_err     = resp_err_q;

endmodule

// File: tb/tb_axi_burst_scheduler.sv
// tb_axi_burst_scheduler
//   Directed bench for axi_burst_scheduler. A small engine model inside cycle() answers
//   command handshakes and produces done pulses; expected commands are queued when a
//   layer is started and compared as each handshake happens.
module tb_axi_burst_scheduler;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        cfg_start = 1'b0;
    logic [31:0] cfg_ifm_base = '0, cfg_ofm_base = '0;
    logic [15:0] cfg_ifm_bursts = '0, cfg_ofm_bursts = '0;
    logic [10:0] ifm_level = '0, ofm_level = '0;
    logic        rd_cmd_valid, wr_cmd_valid;
    logic        rd_cmd_ready = 1'b0, wr_cmd_ready = 1'b0;
    logic [31:0] rd_cmd_addr, wr_cmd_addr;
    logic [7:0]  rd_cmd_len, wr_cmd_len;
    logic        rd_done = 1'b0, wr_done = 1'b0;
    logic [1:0]  wr_resp = 2'b00;
    logic        busy, start_cnn, layer_done, resp_err;

    always #5 ACLK = ~ACLK;

    axi_burst_scheduler dut (
        .ACLK           (ACLK),
        .ARESETN        (ARESETN),
        .cfg_start      (cfg_start),
        .cfg_ifm_base   (cfg_ifm_base),
        .cfg_ofm_base   (cfg_ofm_base),
        .cfg_ifm_bursts (cfg_ifm_bursts),
        .cfg_ofm_bursts (cfg_ofm_bursts),
        .ifm_level      (ifm_level),
        .ofm_level      (ofm_level),
        .rd_cmd_valid   (rd_cmd_valid),
        .rd_cmd_ready   (rd_cmd_ready),
        .rd_cmd_addr    (rd_cmd_addr),
        .rd_cmd_len     (rd_cmd_len),
        .rd_done        (rd_done),
        .wr_cmd_valid   (wr_cmd_valid),
        .wr_cmd_ready   (wr_cmd_ready),
        .wr_cmd_addr    (wr_cmd_addr),
        .wr_cmd_len     (wr_cmd_len),
        .wr_done        (wr_done),
        .wr_resp        (wr_resp),
        .busy           (busy),
        .start_cnn      (start_cnn),
        .layer_done     (layer_done),
        .resp_err       (resp_err)
    );

    int n_checks = 0, n_pass = 0, n_fail = 0;

    // Scoreboard: expected commands in grant order.
    logic        exp_is_wr[$];
    logic [31:0] exp_addr[$];

    // Engine model knobs and observation records.
    int          cyc = 0;
    logic        rd_rdy_en = 1'b1, wr_rdy_en = 1'b1;
    int          rd_lat = 1, wr_lat = 1, rd_pend = 0, wr_pend = 0;
    logic [1:0]  wr_bresp = 2'b00;
    int          rd_hs_cnt, wr_hs_cnt, rd_done_cnt, done2_cyc, done3_cyc;
    int          scnn_cnt, scnn_cyc, ld_cnt, ld_cyc, err_done_cyc, err_seen_cyc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        rd_hs_cnt = 0; wr_hs_cnt = 0; rd_done_cnt = 0; done2_cyc = -1; done3_cyc = -1;
        scnn_cnt = 0; scnn_cyc = -1; ld_cnt = 0; ld_cyc = -1;
        err_done_cyc = -1; err_seen_cyc = -1;
    endtask

    task automatic push_cmd(input logic is_wr, input logic [31:0] addr);
        exp_is_wr.push_back(is_wr);
        exp_addr.push_back(addr);
    endtask

    task automatic sb_pop(input logic is_wr, input logic [31:0] addr);
        chk("sb_nonempty", 64'(exp_addr.size() != 0), 64'd1);
        if (exp_addr.size() != 0) begin
            chk("cmd_kind", 64'(is_wr), 64'(exp_is_wr.pop_front()));
            chk("cmd_addr", 64'(addr), 64'(exp_addr.pop_front()));
        end
    endtask

    task automatic rd_done_now();
        rd_done = 1'b1;
        rd_done_cnt++;
        if (rd_done_cnt == 2) done2_cyc = cyc;
        if (rd_done_cnt == 3) done3_cyc = cyc;
    endtask

    task automatic wr_done_now();
        wr_done = 1'b1;
        wr_resp = wr_bresp;
        if (wr_bresp != 2'b00 && err_done_cyc < 0) err_done_cyc = cyc;
    endtask

    // One clock: wait for the falling edge, observe outputs, drive engine responses.
    task automatic cycle();
        @(negedge ACLK);
        cyc++;
        if (start_cnn === 1'b1) begin scnn_cnt++; scnn_cyc = cyc; end
        if (layer_done === 1'b1) begin ld_cnt++; ld_cyc = cyc; end
        if (resp_err === 1'b1 && err_seen_cyc < 0) err_seen_cyc = cyc;
        rd_done = 1'b0; wr_done = 1'b0; wr_resp = 2'b00;
        if (rd_pend > 0) begin rd_pend--; if (rd_pend == 0) rd_done_now(); end
        if (wr_pend > 0) begin wr_pend--; if (wr_pend == 0) wr_done_now(); end
        rd_cmd_ready = rd_rdy_en;
        wr_cmd_ready = wr_rdy_en;
        if (rd_cmd_valid === 1'b1 && rd_rdy_en) begin
            rd_hs_cnt++;
            sb_pop(1'b0, rd_cmd_addr);
            if (rd_lat == 0) rd_done_now(); else rd_pend = rd_lat;
        end
        if (wr_cmd_valid === 1'b1 && wr_rdy_en) begin
            wr_hs_cnt++;
            sb_pop(1'b1, wr_cmd_addr);
            if (wr_lat == 0) wr_done_now(); else wr_pend = wr_lat;
        end
    endtask

    task automatic start_layer(input logic [31:0] ib, input logic [31:0] ob,
                               input logic [15:0] nr, input logic [15:0] nw);
        clear_obs();
        cfg_ifm_base = ib; cfg_ofm_base = ob;
        cfg_ifm_bursts = nr; cfg_ofm_bursts = nw;
        cfg_start = 1'b1;
        cycle();
        cfg_start = 1'b0;
    endtask

    task automatic wait_layer_done(input string tag);
        int n = 0;
        while (ld_cnt == 0 && n < 2000) begin cycle(); n++; end
        chk(tag, 64'(ld_cnt), 64'd1);
    endtask

    task automatic do_reset();
        ARESETN = 1'b0;
        rd_pend = 0; wr_pend = 0;
        repeat (3) cycle();
        ARESETN = 1'b1;
        cycle();
    endtask

    initial begin
        logic [31:0] held_addr;
        int          bad;

        clear_obs();
        // Reset values
        ARESETN = 1'b0;
        repeat (3) cycle();
        chk("rst_rd_valid", 64'(rd_cmd_valid), 64'd0);
        chk("rst_wr_valid", 64'(wr_cmd_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_start_cnn", 64'(start_cnn), 64'd0);
        chk("rst_layer_done", 64'(layer_done), 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_rd_addr", 64'(rd_cmd_addr), 64'd0);
        chk("rst_wr_addr", 64'(wr_cmd_addr), 64'd0);
        chk("rst_rd_len", 64'(rd_cmd_len), 64'd255);
        chk("rst_wr_len", 64'(wr_cmd_len), 64'd255);
        ARESETN = 1'b1;
        cycle();

        // Three reads, no writes
        ifm_level = 11'd0;
        push_cmd(1'b0, 32'h1000_0000);
        push_cmd(1'b0, 32'h1000_2000);
        push_cmd(1'b0, 32'h1000_4000);
        start_layer(32'h1000_0000, 32'h0, 16'd3, 16'd0);
        chk("t1_arb_valid_low", 64'(rd_cmd_valid), 64'd0);
        chk("t1_busy", 64'(busy), 64'd1);
        cycle();
        chk("t1_valid_2cyc", 64'(rd_cmd_valid), 64'd1);
        wait_layer_done("t1_layer_done");
        chk("t1_rd_hs", 64'(rd_hs_cnt), 64'd3);
        chk("t1_scnn_cnt", 64'(scnn_cnt), 64'd1);
        chk("t1_scnn_timing", 64'(scnn_cyc), 64'(done2_cyc + 1));
        chk("t1_ld_timing", 64'(ld_cyc), 64'(done3_cyc + 2));
        cycle();
        chk("t1_busy_after", 64'(busy), 64'd0);
        chk("t1_ld_pulse", 64'(layer_done), 64'd0);

        // IFM level gating at the FIFO_DEPTH-BURST_LEN boundary
        ifm_level = 11'd1300;
        push_cmd(1'b0, 32'h0000_8000);
        start_layer(32'h0000_8000, 32'h0, 16'd1, 16'd0);
        repeat (5) cycle();
        chk("t2_blocked_hs", 64'(rd_hs_cnt), 64'd0);
        chk("t2_blocked_valid", 64'(rd_cmd_valid), 64'd0);
        ifm_level = 11'd1280;
        cycle();
        chk("t2_valid_1cyc", 64'(rd_cmd_valid), 64'd0);
        cycle();
        chk("t2_valid_2cyc", 64'(rd_cmd_valid), 64'd1);
        wait_layer_done("t2_layer_done");
        chk("t2_scnn_cnt", 64'(scnn_cnt), 64'd1);
        ifm_level = 11'd0;
        cycle();

        // Empty layer
        start_layer(32'h0, 32'h0, 16'd0, 16'd0);
        chk("t3_ld_c1", 64'(layer_done), 64'd0);
        cycle();
        chk("t3_ld_c2", 64'(layer_done), 64'd0);
        cycle();
        chk("t3_ld_c3", 64'(layer_done), 64'd1);
        cycle();
        chk("t3_scnn_none", 64'(scnn_cnt), 64'd0);
        chk("t3_busy_after", 64'(busy), 64'd0);

        // Contested grants, completions in the issue cycle
        do_reset();
        rd_lat = 0; wr_lat = 0;
        ofm_level = 11'd300;
`ifdef AXI_SCHED_RD_PRIORITY_EN
        push_cmd(1'b0, 32'h2000_0000);
        push_cmd(1'b0, 32'h2000_2000);
        push_cmd(1'b1, 32'h3000_0000);
        push_cmd(1'b1, 32'h3000_2000);
`else
        push_cmd(1'b0, 32'h2000_0000);
        push_cmd(1'b1, 32'h3000_0000);
        push_cmd(1'b0, 32'h2000_2000);
        push_cmd(1'b1, 32'h3000_2000);
`endif
        start_layer(32'h2000_0000, 32'h3000_0000, 16'd2, 16'd2);
        wait_layer_done("t4_layer_done");
        chk("t4_rd_hs", 64'(rd_hs_cnt), 64'd2);
        chk("t4_wr_hs", 64'(wr_hs_cnt), 64'd2);
        rd_lat = 1; wr_lat = 1;
        cycle();

        // Back-pressure: valid and address hold while ready is low
        rd_rdy_en = 1'b0;
        push_cmd(1'b0, 32'h5000_0000);
        start_layer(32'h5000_0000, 32'h0, 16'd1, 16'd0);
        cycle();
        held_addr = rd_cmd_addr;
        chk("t5_valid", 64'(rd_cmd_valid), 64'd1);
        chk("t5_addr", 64'(held_addr), 64'h5000_0000);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (rd_cmd_valid !== 1'b1 || rd_cmd_addr !== held_addr) bad++;
        end
        chk("t5_stable_cycles_bad", 64'(bad), 64'd0);
        chk("t5_no_hs", 64'(rd_hs_cnt), 64'd0);
        rd_rdy_en = 1'b1;
        wait_layer_done("t5_layer_done");
        chk("t5_one_hs", 64'(rd_hs_cnt), 64'd1);
        cycle();

        // Write error response
        chk("t6_err_before", 64'(resp_err), 64'd0);
        wr_bresp = 2'b10;
        push_cmd(1'b1, 32'h6000_0000);
        start_layer(32'h0, 32'h6000_0000, 16'd0, 16'd1);
        wait_layer_done("t6_layer_done");
        chk("t6_err_timing", 64'(err_seen_cyc), 64'(err_done_cyc + 1));
        chk("t6_err_at_done", 64'(resp_err), 64'd1);
        wr_bresp = 2'b00;
        cycle();
        chk("t6_err_sticky", 64'(resp_err), 64'd1);
        start_layer(32'h0, 32'h0, 16'd0, 16'd0);
        chk("t6_err_cleared", 64'(resp_err), 64'd0);
        wait_layer_done("t6b_layer_done");
        cycle();

        // Reset while a write command is waiting
        wr_rdy_en = 1'b0;
        push_cmd(1'b1, 32'h7000_0000);
        start_layer(32'h0, 32'h7000_0000, 16'd0, 16'd2);
        cycle();
        chk("t7_wr_valid", 64'(wr_cmd_valid), 64'd1);
        ARESETN = 1'b0;
        cycle();
        chk("t7_rst_wr_valid", 64'(wr_cmd_valid), 64'd0);
        chk("t7_rst_busy", 64'(busy), 64'd0);
        chk("t7_rst_wr_addr", 64'(wr_cmd_addr), 64'd0);
        ARESETN = 1'b1;
        exp_is_wr.delete();
        exp_addr.delete();
        rd_pend = 0; wr_pend = 0;
        wr_rdy_en = 1'b1;
        cycle();
        push_cmd(1'b1, 32'h7000_0000);
        start_layer(32'h0, 32'h7000_0000, 16'd0, 16'd1);
        wait_layer_done("t7_layer_done");
        chk("t7_wr_hs", 64'(wr_hs_cnt), 64'd1);
        cycle();

        chk("sb_drained", 64'(exp_addr.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_burst_scheduler.md
# axi_burst_scheduler

Sequences one convolution layer's AXI traffic by deciding when, and at which address, the AXI master engine issues each burst. It issues IFM read bursts into the input FIFO and OFM write bursts out of the output FIFO. Read and write requesters share the single command path through a round-robin arbiter. Read bursts are gated by IFM FIFO free space; write bursts are gated by OFM FIFO fill level. The block sits between the layer controller (config/start) and the AXI master engine (command/done handshakes), and also produces the CNN start pulse and the layer-done pulse.

## Interface
Parameters:
- ADDR_WIDTH, 32, AXI address width
- AXI_WIDTH, 256, data beat width in bits; BURST_BYTES = BURST_LEN*AXI_WIDTH/8
- LEN_WIDTH, 8, AxLEN width
- BURST_LEN, 256, beats per burst (cmd_len = BURST_LEN-1)
- FIFO_DEPTH, 1536, IFM FIFO depth in beats
- LVL_WIDTH, 11, FIFO level width
- NB_WIDTH, 16, burst-count width

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  synchronous reset, active-low; one clock, all state sampled on rising ACLK
- cfg_start  in  1  one-cycle layer start pulse
- cfg_ifm_base, cfg_ofm_base  in  ADDR_WIDTH  byte base addresses, sampled at start
- cfg_ifm_bursts, cfg_ofm_bursts  in  NB_WIDTH  bursts per layer, sampled at start
- ifm_level  in  LVL_WIDTH  IFM FIFO occupancy (beats)
- ofm_level  in  LVL_WIDTH  OFM FIFO occupancy (beats)
- rd_cmd_valid  out  1; rd_cmd_ready  in  1; rd_cmd_addr  out  ADDR_WIDTH; rd_cmd_len  out  LEN_WIDTH
- rd_done  in  1  pulse: last read beat accepted (RLAST&RVALID&RREADY)
- wr_cmd_valid  out  1; wr_cmd_ready  in  1; wr_cmd_addr  out  ADDR_WIDTH; wr_cmd_len  out  LEN_WIDTH
- wr_done  in  1  pulse: B handshake; wr_resp  in  2  BRESP qualified by wr_done
- busy  out  1  layer in progress
- start_cnn  out  1  one-cycle pulse
- layer_done  out  1  one-cycle pulse
- resp_err  out  1  sticky, any BRESP != OKAY

## Operation
- States: IDLE, ARB, ISSUE_RD, ISSUE_WR, DRAIN, DONE.
- IDLE: busy=0. On cfg_start, latch config, clear counters and resp_err, and go to ARB. cfg_start outside IDLE is ignored.
- Counters: rd_issued, rd_compl, wr_issued, wr_compl (NB_WIDTH each). At most one read and one write are outstanding.
- rd_elig = rd_issued<cfg_ifm_bursts & no read outstanding & ifm_level <= FIFO_DEPTH-BURST_LEN.
- wr_elig = wr_issued<cfg_ofm_bursts & no write outstanding & ofm_level >= BURST_LEN.
- ARB grants exactly one of the eligible requesters:
  - both eligible: grant the side not granted last; last_grant resets to write, so the first contested grant goes to read;
  - one eligible: grant it;
  - none eligible and all bursts issued: go to DRAIN;
  - otherwise stay in ARB.
- ISSUE_RD: assert rd_cmd_valid with rd_cmd_addr = ifm_base + rd_issued*BURST_BYTES. On ready, increment rd_issued and return to ARB.
- ISSUE_WR: same pattern using the ofm side and wr_issued.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap is silent.
- DRAIN: wait until rd_compl==cfg_ifm_bursts and wr_compl==cfg_ofm_bursts, then go to DONE.
- DONE: layer_done=1 for one cycle, then go to IDLE.
- rd_done/wr_done increment the completion counters in any state, including the same cycle as an issue handshake. A done with no burst outstanding is ignored.
- start_cnn pulses once per layer, the cycle after rd_compl reaches min(2, cfg_ifm_bursts). It never pulses when cfg_ifm_bursts=0.
- resp_err sets on wr_done with wr_resp!=2'b00. The layer continues after an error.

## Timing
- Reset values: rd_cmd_valid=wr_cmd_valid=0, busy=0, start_cnn=0, layer_done=0, resp_err=0, addr=0, len=BURST_LEN-1, state IDLE, counters 0.
- Reset asserted mid-layer: all outputs return to reset values at the next edge. In-flight engine traffic is the engine's responsibility.
- All outputs are registered.
- cfg_start to first cmd_valid: 2 cycles (IDLE→ARB→ISSUE).
- valid, addr and len hold stable until ready. Valid drops the cycle after the handshake.
- A handshake in ISSUE_x means the next issue comes no earlier than 2 cycles later.
- Both burst counts = 0: cfg_start → layer_done pulse 3 cycles later (ARB→DRAIN→DONE).

## Configuration
- AXI_SCHED_RD_PRIORITY_EN defined: fixed priority, reads always win when both are eligible.
- AXI_SCHED_RD_PRIORITY_EN undefined (default): round-robin as described above.

## Structure
- Package axi_sched_pkg holds:
  - sched_state_t enum;
  - RESP_OKAY constant;
  - BURST_BYTES computation function.
- Sub-module axi_sched_rr_arb: 2-way round-robin arbiter with last_grant register; macro-controlled priority lives inside it.

## Test plan
- cfg_ifm_bursts=3, cfg_ofm_bursts=0, ifm_level=0 → reads at base, base+8192, base+16384; start_cnn one cycle after 2nd rd_done; layer_done after 3rd rd_done.
- ifm_level=1300 → no read issued; drop ifm_level to 1280 → rd_cmd_valid 2 cycles later.
- Both eligible continuously, 2+2 bursts → grant order R,W,R,W; with AXI_SCHED_RD_PRIORITY_EN → R,R,W,W.
- rd_cmd_ready held low 10 cycles → valid and addr stable throughout; exactly one issue counted.
- wr_done with wr_resp=2'b10 → resp_err=1 next cycle, stays 1 through layer_done, cleared by next cfg_start.
- ARESETN low during ISSUE_WR → wr_cmd_valid=0 and busy=0 next edge; new cfg_start restarts at the ofm base.
